ser_rx_fifo: RTL
================

Name: ser_rx_fifo

Overview:
- Parametrised successor of the terminal's fixed 8N1 serial receiver.
- Adds an oversampled, majority-voted bit detector with configurable data width and parity, plus per-byte error flags.
- Buffers received characters in an on-chip FIFO with a valid/ready read port, so the terminal state machine and future consumers can stall without losing input.
- Sits between the serialrx pin and the RX state machine in the pixclk (25 MHz) domain.

Parameters:
- CLK_HZ, 25000000, pixclk frequency.
- BAUD, 57600, line rate.
- OVERSAMPLE, 16, sample ticks per bit; must be even and >= 8.
- DATA_BITS, 8, character width; legal range 5..9.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- FIFO_DEPTH, 16, entries; must be a power of 2 and >= 2.

Ports:
- pixclk  in  1  sole clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- serialrx  in  1  asynchronous line input; idle high.
- rd_valid  out  1  FIFO non-empty.
- rd_ready  in  1  consumer accepts the head entry.
- rd_data  out  DATA_BITS  head character.
- rd_ferr  out  1  head entry had a framing error.
- rd_perr  out  1  head entry had a parity error; always 0 when PARITY = 0.
- level  out  $clog2(FIFO_DEPTH)+1  current entry count.
- overflow  out  1  sticky: a character was dropped.
- clr_overflow  in  1  clears overflow.
- brk  out  1  break pulse (see Optional Feature).

Behaviour:
- Reset values:
  - all outputs 0; synchroniser flops 1; state IDLE; FIFO empty; tick divider 0.
- Sample tick:
  - Divider reloads at DIV = CLK_HZ/(BAUD*OVERSAMPLE) - 1, rounded down (26 at defaults); one tick per wrap.
  - The divider free-runs and is re-phased to 0 on start detect.
- Input:
  - 2-FF synchroniser; all decisions use the synchronised value.
- Bit sampling:
  - Majority of 3 samples taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within each bit.
- States IDLE, START, DATA, PARITY, STOP:
  - IDLE -> START on synchronised serialrx = 0.
  - START: a majority of 1 is a false start -> IDLE, and nothing is pushed. Otherwise -> DATA at the bit boundary.
  - DATA: shifts DATA_BITS bits LSB-first -> PARITY if PARITY != 0, else -> STOP.
  - PARITY: computes perr = sampled bit != expected (even: XOR of data; odd: its inverse).
  - STOP: at the mid-bit majority, ferr = (stop == 0). Push the entry and return to IDLE in the same cycle. No wait for end of stop bit, so back-to-back frames are accepted.
- Errored characters are still pushed, with their flags set.
- FIFO:
  - First-word fall-through; rd_valid rises 1 cycle after the push cycle.
  - Pop occurs on rd_valid && rd_ready.
  - rd_data/rd_ferr/rd_perr are stable while rd_valid && !rd_ready.
- Full FIFO:
  - A push when full with no simultaneous pop is dropped and overflow <= 1.
  - Push + pop in the same cycle when full: both happen, level stays FIFO_DEPTH, no overflow.
  - Push + pop when empty: entry stored, level = 1 next cycle (no bypass).
- overflow clears on clr_overflow. A new drop in the same cycle wins: overflow stays 1.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally; level = wr_cnt - rd_cnt using one extra bit.
- Reset mid-frame: the frame is abandoned and the FIFO is emptied immediately (asynchronous).

Optional Feature:
- Macro SER_RX_BREAK_DETECT_EN.
- Defined:
  - A frame whose data bits, parity bit (if any) and stop bit all sample 0 is a break.
  - It is not pushed; brk pulses high for 1 cycle at the stop sample.
  - The receiver then waits in IDLE until serialrx has been sampled high before accepting a new start.
- Undefined:
  - brk is tied 0.
  - Such a frame is pushed as data 0 with rd_ferr = 1.
  - There is no wait-for-high, so a held-low line yields repeated 0/ferr entries.

Decomposition:
- Package ser_pkg holds:
  - the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD);
  - the rx state enum;
  - a function computing DIV from CLK_HZ, BAUD and OVERSAMPLE.
- One sub-module, ser_fifo: a parametrised width/depth synchronous FIFO with the full/empty/level and simultaneous-push/pop rules above.
- The entry width is DATA_BITS+2.

Test Plan:
- 8N1 at defaults, send 0x41 then 0x0D back-to-back with rd_ready = 1 -> two pops of 0x41 and 0x0D, ferr = perr = 0, overflow = 0.
- PARITY = 1, send 0x03 with parity bit 1 -> rd_data = 0x03, rd_perr = 1; resend with parity bit 0 -> rd_perr = 0.
- Glitch: serialrx low for 5 pixclk cycles -> no push, level stays 0, state returns to IDLE.
- Stop bit driven 0 on 0x55 -> entry 0x55 with rd_ferr = 1.
- rd_ready = 0, send 17 characters 0x00..0x10 with FIFO_DEPTH = 16 -> level = 16, overflow = 1, and pops return 0x00..0x0F. Then pulse clr_overflow -> overflow = 0.
- With SER_RX_BREAK_DETECT_EN, hold the line low for 2 frame times -> exactly one brk pulse, level = 0. Release high, then send 0x7E -> 0x7E received.

Source files
------------

// File: rtl/ser_pkg.sv
// ser_pkg: shared constants, receiver state encoding and baud divider helper
// for the ser_rx_fifo serial receiver.
package ser_pkg;

   // Parity modes selected by the PARITY parameter.
   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   // Receiver frame position.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_e;

   // Sample-tick divider reload value, rounded down.
   function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
      return (clk_hz / (baud * oversample)) - 1;
   endfunction

endpackage

// File: rtl/ser_fifo.sv
// ser_fifo: first-word fall-through synchronous FIFO with level output and a
// sticky overflow flag. Pointers are free-running counters one bit wider than
// the address so full and empty are distinguished without extra state.
module ser_fifo
   import ser_pkg::*;
#(
   parameter int WIDTH = 10,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop_ready,
   output logic                     rd_valid,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   level,
   input  logic                     clr_overflow,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

   logic [AW:0]      wr_cnt_q, wr_cnt_d;
   logic [AW:0]      rd_cnt_q, rd_cnt_d;
   logic             overflow_q, overflow_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic empty, full, do_pop, do_push, drop;

   assign level   = wr_cnt_q - rd_cnt_q;
   assign empty   = (level == '0);
   assign full    = (level == FULL_LVL);
   assign do_pop  = !empty && pop_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign drop    = push && full && !do_pop;

   assign rd_valid = !empty;
   assign rd_data  = empty ? '0 : mem_q[rd_cnt_q[AW-1:0]];
   assign overflow = overflow_q;

   // Next pointer and sticky overflow values.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      wr_cnt_d   = wr_cnt_q;
      rd_cnt_d   = rd_cnt_q;
      overflow_d = overflow_q;
      if (do_push) wr_cnt_d = wr_cnt_q + 1'b1;
      if (do_pop)  rd_cnt_d = rd_cnt_q + 1'b1;
      if (drop)              overflow_d = 1'b1;
      else if (clr_overflow) overflow_d = 1'b0;
   end

   // Pointer and flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_cnt_q   <= wr_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   // Entry storage.
   // NOTE: the storage array has no reset; pointers define validity, and rd_data is gated while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_cnt_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/ser_rx_fifo.sv
// ser_rx_fifo: oversampled, majority-voted serial receiver with configurable
// data width and parity, feeding a FWFT FIFO with per-character error flags.
// Optional break detection is enabled by defining SER_RX_BREAK_DETECT_EN.
module ser_rx_fifo
   import ser_pkg::*;
#(
   parameter int CLK_HZ     = 25000000,
   parameter int BAUD       = 57600,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          pixclk,
   input  logic                          rst_n,
   input  logic                          serialrx,
   output logic                          rd_valid,
   input  logic                          rd_ready,
   output logic [DATA_BITS-1:0]          rd_data,
   output logic                          rd_ferr,
   output logic                          rd_perr,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow,
   input  logic                          clr_overflow,
   output logic                          brk
);

   localparam int DIV    = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
   localparam int DIV_W  = (DIV < 1) ? 1 : $clog2(DIV + 1);
   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_BITS + 1);
   localparam int ENT_W  = DATA_BITS + 2;

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV);
   localparam logic [TICK_W-1:0] SMP0      = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] SMP1      = TICK_W'(OVERSAMPLE / 2);
   localparam logic [TICK_W-1:0] SMP2      = TICK_W'(OVERSAMPLE / 2 + 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS);

   logic [1:0]           sync_q, sync_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [1:0]           samp_q, samp_d;
   logic                 perr_q, perr_d;
   rx_state_e            state_q, state_d;

   logic             rx_s, tick, decide, bit_end, maj, exp_par, start_ok;
   logic             push;
   logic [ENT_W-1:0] push_data, rd_entry;

`ifdef SER_RX_BREAK_DETECT_EN
   logic wait_high_q, wait_high_d;
   logic zero_q, zero_d;
   logic brk_q, brk_d;

   // After a break the line must be seen high before a new start counts.
   assign start_ok = !rx_s && !wait_high_q;
   assign brk      = brk_q;
`else
   assign start_ok = !rx_s;
   assign brk      = 1'b0;
`endif

   assign rx_s    = sync_q[1];
   assign tick    = (div_q == DIV_LAST);
   assign decide  = tick && (tick_cnt_q == SMP2);
   assign bit_end = tick && (tick_cnt_q == TICK_LAST);
   // Two stored samples plus the live third one form the 2-of-3 vote.
   assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
   assign exp_par = (^shreg_q) ^ (PARITY == PAR_ODD);

   // Entry layout: {perr, ferr, data}; the stop-bit vote sets ferr.
   assign push_data = {perr_q, ~maj, shreg_q};

   // Two-stage synchroniser shift.
   always_comb begin
      sync_d = {sync_q[0], serialrx};
   end

   // Receive FSM, tick divider and bit-position bookkeeping.
   always_comb begin
      state_d    = state_q;
      div_d      = tick ? '0 : div_q + 1'b1;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      samp_d     = samp_q;
      perr_d     = perr_q;
      push       = 1'b0;
`ifdef SER_RX_BREAK_DETECT_EN
      wait_high_d = wait_high_q;
      zero_d      = zero_q;
      brk_d       = 1'b0;
`endif
      if (tick) tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
      if (tick && tick_cnt_q == SMP0) samp_d[0] = rx_s;
      if (tick && tick_cnt_q == SMP1) samp_d[1] = rx_s;

      case (state_q)
         ST_IDLE: begin
`ifdef SER_RX_BREAK_DETECT_EN
            if (rx_s) wait_high_d = 1'b0;
            zero_d = 1'b1;
`endif
            if (start_ok) begin
               // Re-phase the bit clock to the falling edge of the start bit.
               state_d    = ST_START;
               div_d      = '0;
               tick_cnt_d = '0;
               bit_cnt_d  = '0;
               perr_d     = 1'b0;
            end
         end
         ST_START: begin
            if (decide && maj) state_d = ST_IDLE;
            else if (bit_end)  state_d = ST_DATA;
         end
         ST_DATA: begin
            if (decide) begin
               shreg_d   = {maj, shreg_q[DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef SER_RX_BREAK_DETECT_EN
               if (maj) zero_d = 1'b0;
`endif
            end
            if (bit_end && bit_cnt_q == BIT_LAST)
               state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
         end
         ST_PARITY: begin
            if (decide) begin
               perr_d = (maj != exp_par);
`ifdef SER_RX_BREAK_DETECT_EN
               if (maj) zero_d = 1'b0;
`endif
            end
            if (bit_end) state_d = ST_STOP;
         end
         ST_STOP: begin
            // Finish at the mid-bit vote so a following start edge is not missed.
            if (decide) begin
               state_d = ST_IDLE;
`ifdef SER_RX_BREAK_DETECT_EN
               if (zero_q && !maj) begin
                  brk_d       = 1'b1;
                  wait_high_d = 1'b1;
               end else begin
                  push = 1'b1;
               end
`else
               push = 1'b1;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Receiver state registers; the synchroniser resets to the idle-high level.
   always_ff @(posedge pixclk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= 2'b11;
         div_q      <= '0;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         samp_q     <= '0;
         perr_q     <= 1'b0;
         state_q    <= ST_IDLE;
`ifdef SER_RX_BREAK_DETECT_EN
         wait_high_q <= 1'b0;
         zero_q      <= 1'b0;
         brk_q       <= 1'b0;
`endif
      end else begin
         sync_q     <= sync_d;
         div_q      <= div_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         samp_q     <= samp_d;
         perr_q     <= perr_d;
         state_q    <= state_d;
`ifdef SER_RX_BREAK_DETECT_EN
         wait_high_q <= wait_high_d;
         zero_q      <= zero_d;
         brk_q       <= brk_d;
`endif
      end
   end

   ser_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk          (pixclk),
      .rst_n        (rst_n),
      .push         (push),
      .push_data    (push_data),
      .pop_ready    (rd_ready),
      .rd_valid     (rd_valid),
      .rd_data      (rd_entry),
      .level        (level),
      .clr_overflow (clr_overflow),
      .overflow     (overflow)
   );

   assign rd_data = rd_entry[DATA_BITS-1:0];
   assign rd_ferr = rd_entry[DATA_BITS];
   assign rd_perr = rd_entry[DATA_BITS+1];

endmodule
